// File: rtl/memory_access_arbiter_pkg.sv
// Shared types for the Slave_Memory access arbiter: state encoding, address width, mux bus payload.
package memory_access_arbiter_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned MUX_W  = 2 * ADDR_W + 1;

  typedef enum logic [1:0] {
    SLAVE   = 2'd0,
    DRAIN   = 2'd1,
    MASTER  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] read_addr;
    logic [ADDR_W-1:0] write_addr;
    logic              write;
  } mem_bus_t;

endpackage

// File: rtl/memory_access_arbiter_if.sv
// Requester/memory signal bundle; the arbiter uses the slave modport, the driving side uses master.
interface memory_access_arbiter_if;
  import memory_access_arbiter_pkg::*;

  logic              master_req;
  logic              master_grant;
  logic              master_has_control;
  logic              slave_stall;
  logic              hold_expired;
  logic [ADDR_W-1:0] slave_read_addr;
  logic [ADDR_W-1:0] slave_write_addr;
  logic              slave_write;
  logic [ADDR_W-1:0] master_read_addr;
  logic [ADDR_W-1:0] master_write_addr;
  logic              master_write;
  logic [ADDR_W-1:0] read_addr;
  logic [ADDR_W-1:0] write_addr;
  logic              write;

  modport slave (
    input  master_req, slave_read_addr, slave_write_addr, slave_write,
           master_read_addr, master_write_addr, master_write,
    output master_grant, master_has_control, slave_stall, hold_expired,
           read_addr, write_addr, write
  );

  modport master (
    output master_req, slave_read_addr, slave_write_addr, slave_write,
           master_read_addr, master_write_addr, master_write,
    input  master_grant, master_has_control, slave_stall, hold_expired,
           read_addr, write_addr, write
  );

endinterface

// File: rtl/memory_access_arbiter_access_mux.sv
// Access_Mux: selects between the slave (sel=0) and master (sel=1) memory bus.
module memory_access_arbiter_access_mux #(
  parameter int unsigned W = 11
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/memory_access_arbiter.sv
// Request/grant arbiter handing the Slave_Memory port between the slave core and an external master.
// Optional forced release after HOLD_MAX granted cycles when MEM_ARB_HOLD_LIMIT_EN is defined.
module memory_access_arbiter
  import memory_access_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX  = 16,
  parameter int unsigned DRAIN_CYC = 1
) (
  input logic                    clk,
  input logic                    reset,
  memory_access_arbiter_if.slave bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  if (DRAIN_CYC < 1 || HOLD_MAX < 1) begin : g_cfg_check
    $error("memory_access_arbiter: DRAIN_CYC and HOLD_MAX must be at least 1");
  end

  arb_state_e         state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               grant_q, grant_d;
  logic               stall_q, stall_d;
  logic               block_q, block_d;
  logic               accept_c;

`ifdef MEM_ARB_HOLD_LIMIT_EN
  localparam int unsigned HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              armed_q, armed_d;
  logic              expired_q, expired_d;

  // After a forced release the master must drop its request before it is heard again.
  assign accept_c = bus.master_req & armed_q;
`else
  assign accept_c = bus.master_req;
`endif

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
`ifdef MEM_ARB_HOLD_LIMIT_EN
    hold_cnt_d  = hold_cnt_q;
    armed_d     = armed_q | ~bus.master_req;
    expired_d   = 1'b0;
`endif
    case (state_q)
      SLAVE: begin
        if (accept_c) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
`ifdef MEM_ARB_HOLD_LIMIT_EN
          hold_cnt_d  = '0;
`endif
        end
      end
      DRAIN: begin
        if (!bus.master_req) begin
          state_d = RELEASE;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d = MASTER;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      MASTER: begin
        if (!bus.master_req) begin
          state_d = RELEASE;
`ifdef MEM_ARB_HOLD_LIMIT_EN
        end else if (hold_cnt_q == HOLD_W'(HOLD_MAX - 1)) begin
          state_d   = RELEASE;
          expired_d = 1'b1;
          armed_d   = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end
      end
      RELEASE: state_d = SLAVE;
      default: state_d = SLAVE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    grant_d = (state_d == MASTER);
    stall_d = (state_d != SLAVE);
    block_d = (state_d == DRAIN) || (state_d == RELEASE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SLAVE;
      drain_cnt_q <= '0;
      grant_q     <= 1'b0;
      stall_q     <= 1'b0;
      block_q     <= 1'b0;
`ifdef MEM_ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= '0;
      armed_q     <= 1'b1;
      expired_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      grant_q     <= grant_d;
      stall_q     <= stall_d;
      block_q     <= block_d;
`ifdef MEM_ARB_HOLD_LIMIT_EN
      hold_cnt_q  <= hold_cnt_d;
      armed_q     <= armed_d;
      expired_q   <= expired_d;
`endif
    end
  end

  // Grant and mux select are the same condition, so one register drives both.
  assign bus.master_grant       = grant_q;
  assign bus.master_has_control = grant_q;
  assign bus.slave_stall        = stall_q;
`ifdef MEM_ARB_HOLD_LIMIT_EN
  assign bus.hold_expired       = expired_q;
`else
  assign bus.hold_expired       = 1'b0;
`endif

  mem_bus_t slave_bus_c, master_bus_c, mem_bus_c;

  assign slave_bus_c  = {bus.slave_read_addr, bus.slave_write_addr, bus.slave_write};
  assign master_bus_c = {bus.master_read_addr, bus.master_write_addr, bus.master_write};

  memory_access_arbiter_access_mux #(
    .W (MUX_W)
  ) u_access_mux (
    .sel (grant_q),
    .in0 (slave_bus_c),
    .in1 (master_bus_c),
    .out (mem_bus_c)
  );

  // Write gate sits after the mux: no memory write while draining, releasing or in reset.
  assign bus.read_addr  = mem_bus_c.read_addr;
  assign bus.write_addr = mem_bus_c.write_addr;
  assign bus.write      = mem_bus_c.write & ~block_q & reset;

endmodule

// File: doc/memory_access_arbiter.md
Name: memory_access_arbiter

Overview:
Arbitrates the single Slave_Memory access port between the Slave core and an external master (debug/host loader). Replaces the hard-wired master_has_control with a request/grant handshake. Stalls the slave at a safe point, grants the master exclusive access, and returns control cleanly. Drives the shared read_addr/write_addr/write bus through an internal Access_Mux.

Parameters:
ADDR_W, 5, memory address width (31 usable words, addr 0..30)
HOLD_MAX, 16, max consecutive master-granted cycles before forced release (only with hold limit enabled)
DRAIN_CYC, 1, cycles between slave stall and master grant, so any in-flight slave write retires

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
master_req  in  1  master requests memory; level, held until done
master_grant  out  1  master owns the memory port this cycle
master_has_control  out  1  Access_Mux select (1 = master path)
slave_stall  out  1  slave must hold state and issue no new access
slave_read_addr  in  ADDR_W  slave read address
slave_write_addr  in  ADDR_W  slave write address
slave_write  in  1  slave write strobe
master_read_addr  in  ADDR_W  master read address
master_write_addr  in  ADDR_W  master write address
master_write  in  1  master write strobe
read_addr  out  ADDR_W  to memory
write_addr  out  ADDR_W  to memory
write  out  1  to memory write strobe
hold_expired  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (reset low, async): state SLAVE, master_grant=0, master_has_control=0, slave_stall=0, hold_expired=0, counters 0. Mux outputs follow the slave path; write is forced 0 while reset is low.
- States: SLAVE, DRAIN, MASTER, RELEASE; registered, one transition per clk.
- SLAVE: mux on slave path. master_req=1 -> DRAIN, slave_stall=1 from the next cycle.
- DRAIN: slave_stall=1, mux still on slave path, write forced 0. Counter counts DRAIN_CYC cycles, then MASTER. master_req dropping in DRAIN -> RELEASE (grant never asserted).
- MASTER: master_grant=1, master_has_control=1, slave_stall=1. Master signals pass combinationally to memory. master_req=0 -> RELEASE.
- RELEASE: one cycle. master_grant=0, master_has_control=0, write forced 0, slave_stall=1. Then SLAVE with stall deasserted.
- Latency: request to grant is DRAIN_CYC+1 cycles (req sampled high in cycle 0, grant high in cycle DRAIN_CYC+1). Release to slave resume is 2 cycles.
- write to memory is never asserted in DRAIN or RELEASE, regardless of either requester.
- Addresses > 30 pass through unmodified; range checking is the memory's responsibility.
- master_req re-asserted during RELEASE is ignored until SLAVE. SLAVE then sees it next cycle, so the slave gets at least one unstalled cycle between master tenures.
- Reset asserted mid-tenure: immediate return to SLAVE. Any master write in that cycle is suppressed.

Optional Feature:
Macro MEM_ARB_HOLD_LIMIT_EN.
- Defined: a hold counter increments each MASTER cycle. On reaching HOLD_MAX, the block forces RELEASE and pulses hold_expired for 1 cycle. master_req must then drop for at least one cycle before a new request is accepted (re-arm flag).
- Undefined: the master holds indefinitely, hold_expired is tied 0, and no counter is built.

Decomposition:
- Shared package: state encoding constants (SLAVE=2'd0, DRAIN=2'd1, MASTER=2'd2, RELEASE=2'd3), ADDR_W, mux bus width 2*ADDR_W+1 = 11.
- Sub-module: reuse the existing Access_Mux #(11), instantiated inside. The write-force gate is applied after the mux.

Test Plan:
- Reset idle: reset low then high, slave_write=1 @ addr 3 -> write=1, write_addr=3, master_grant=0, slave_stall=0.
- Grant timing: master_req high at cycle 0, DRAIN_CYC=1 -> slave_stall=1 at cycle 1, master_grant=1 at cycle 2, master_write @ addr 7 reaches memory at cycle 2.
- Drain suppression: slave_write=1 held through DRAIN and RELEASE -> write=0 in those cycles.
- Release: master_req drops in MASTER -> one RELEASE cycle with write=0, then slave_stall=0 and slave addresses back on the bus.
- Abort: master_req pulses for 1 cycle -> DRAIN, then RELEASE, then SLAVE, with master_grant never 1.
- Hold limit (MEM_ARB_HOLD_LIMIT_EN, HOLD_MAX=4): master_req held -> grant for exactly 4 cycles, hold_expired pulse, no re-grant until master_req toggles low. Async reset mid-MASTER -> outputs at reset values without waiting for a clk edge.
